// File: rtl/pattern_match_pkg.sv
// rtl/pattern_match_pkg.sv - shared defaults, width helper and status type for the pattern matcher
package pattern_match_pkg;

    localparam int DEFAULT_DATA_W  = 8;
    localparam int DEFAULT_MAX_LEN = 8;
    localparam int DEFAULT_CNT_W   = 16;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    typedef struct packed {
        logic                     found;
        logic                     overrun;
        logic [DEFAULT_CNT_W-1:0] count;
    } match_status_t;

endpackage

// File: rtl/symbol_window.sv
// rtl/symbol_window.sv - history shift register of accepted symbols with saturating fill count
module symbol_window
    import pattern_match_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    localparam int LEN_W  = len_w(MAX_LEN)
) (
    input  logic                             clk,
    input  logic                             reset_sync_n,
    input  logic                             shift,
    input  logic                             flush,
    input  logic [DATA_W-1:0]                din,
    output logic [MAX_LEN-1:0][DATA_W-1:0]   hist,
    output logic [LEN_W-1:0]                 fill
);

    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);

    // Flush only forgets the fill; stale history is masked by fill in the comparator.
    always_ff @(posedge clk) begin
        if (!reset_sync_n) begin
            hist <= '0;
            fill <= '0;
        end else begin
            if (shift) begin
                hist[0] <= din;
                for (int k = 1; k < MAX_LEN; k++) begin
                    hist[k] <= hist[k-1];
                end
            end
            if (flush) begin
                fill <= '0;
            end else if (shift && fill != MAX_L) begin
                fill <= fill + ONE_L;
            end
        end
    end

endmodule

// File: rtl/seq_pattern_matcher.sv
// rtl/seq_pattern_matcher.sv - programmable symbol pattern detector with sticky flag, overrun and counter
module seq_pattern_matcher
    import pattern_match_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    parameter int CNT_W   = DEFAULT_CNT_W,
    localparam int LEN_W  = len_w(MAX_LEN),
    localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic              clk,
    input  logic              reset_sync_n,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [DATA_W-1:0] cfg_char,
    input  logic              cfg_len_we,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              overlap_en,
    input  logic              ack,
    output logic              found_pattern,
    output logic              match_pulse,
    output logic              overrun,
    output logic [CNT_W-1:0]  match_count
);

    localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [MAX_LEN-1:0][DATA_W-1:0] pat_r;
    logic [MAX_LEN-1:0][DATA_W-1:0] hist;
    logic [MAX_LEN-1:0][DATA_W-1:0] cand;
    logic [LEN_W-1:0]               len_r;
    logic [LEN_W-1:0]               supp_r;
    logic [LEN_W-1:0]               fill;
    logic [LEN_W-1:0]               fill_next;
    logic [MAX_LEN-1:0]             sym_eq;
    logic                           cfg_any;
    logic                           accept;
    logic                           len_ok;
    logic                           match;

    assign cfg_any = cfg_we | cfg_len_we;
    assign accept  = data_valid & ~cfg_any;

    symbol_window #(
        .DATA_W  (DATA_W),
        .MAX_LEN (MAX_LEN)
    ) u_window (
        .clk          (clk),
        .reset_sync_n (reset_sync_n),
        .shift        (accept),
        .flush        (cfg_any),
        .din          (data),
        .hist         (hist),
        .fill         (fill)
    );

    // Window as it will look once the current symbol is accepted.
    always_comb begin
        cand    = '0;
        cand[0] = data;
        for (int k = 1; k < MAX_LEN; k++) begin
            cand[k] = hist[k-1];
        end
    end

    for (genvar i = 0; i < MAX_LEN; i++) begin : g_cmp
        logic [LEN_W-1:0]  pos;
        logic [DATA_W-1:0] sym;
        assign pos = len_r - LEN_W'(i + 1);
        always_comb begin
            sym = '0;
            for (int k = 0; k < MAX_LEN; k++) begin
                if (pos == LEN_W'(k)) sym = cand[k];
            end
        end
        assign sym_eq[i] = (LEN_W'(i) >= len_r) || (sym == pat_r[i]);
    end

    assign fill_next = (fill == MAX_L) ? fill : fill + ONE_L;
    assign len_ok    = (len_r != '0) && (len_r <= MAX_L);
    assign match     = accept && len_ok && (supp_r == '0) && (fill_next >= len_r) && (&sym_eq);

    always_ff @(posedge clk) begin
        if (!reset_sync_n) begin
            pat_r         <= '0;
            len_r         <= '0;
            supp_r        <= '0;
            match_pulse   <= 1'b0;
            found_pattern <= 1'b0;
            overrun       <= 1'b0;
            match_count   <= '0;
        end else begin
            if (cfg_we) begin
                for (int k = 0; k < MAX_LEN; k++) begin
                    if (cfg_idx == IDX_W'(k)) pat_r[k] <= cfg_char;
                end
            end
            if (cfg_len_we) len_r <= cfg_len;

            if (cfg_any || overlap_en) begin
                supp_r <= '0;
            end else if (match) begin
                supp_r <= len_r - ONE_L;
            end else if (accept && supp_r != '0) begin
                supp_r <= supp_r - ONE_L;
            end

            match_pulse   <= match;
            found_pattern <= match | (found_pattern & ~ack);
            overrun       <= (match & found_pattern & ~ack) | (overrun & ~ack);
            if (match && match_count != CNT_MAX) begin
                match_count <= match_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_seq_pattern_matcher.sv
// tb/tb_seq_pattern_matcher.sv - directed and randomized bench for seq_pattern_matcher
module tb_seq_pattern_matcher;

    localparam int MAX_LEN = 8;

    logic       clk = 1'b0;
    logic       reset_sync_n = 1'b0;
    logic       data_valid = 1'b0;
    logic [7:0] data = '0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_idx = '0;
    logic [7:0] cfg_char = '0;
    logic       cfg_len_we = 1'b0;
    logic [3:0] cfg_len = '0;
    logic       overlap_en = 1'b0;
    logic       ack = 1'b0;

    logic        found_pattern, match_pulse, overrun;
    logic [15:0] match_count;
    logic        found_s, pulse_s, overrun_s;
    logic [1:0]  count_s;

    int passed = 0;
    int total  = 0;

    // Reference state: accepted symbols since last flush, held as a plain queue.
    logic [7:0] m_pat [MAX_LEN];
    logic [7:0] m_q [$];
    int         m_len, m_pos, m_last_end, m_cnt;
    logic       m_found, m_ovr, m_pulse;

    always #5 clk = ~clk;

    seq_pattern_matcher dut (
        .clk           (clk),
        .reset_sync_n  (reset_sync_n),
        .data_valid    (data_valid),
        .data          (data),
        .cfg_we        (cfg_we),
        .cfg_idx       (cfg_idx),
        .cfg_char      (cfg_char),
        .cfg_len_we    (cfg_len_we),
        .cfg_len       (cfg_len),
        .overlap_en    (overlap_en),
        .ack           (ack),
        .found_pattern (found_pattern),
        .match_pulse   (match_pulse),
        .overrun       (overrun),
        .match_count   (match_count)
    );

    seq_pattern_matcher #(.CNT_W(2)) dut_sat (
        .clk           (clk),
        .reset_sync_n  (reset_sync_n),
        .data_valid    (data_valid),
        .data          (data),
        .cfg_we        (cfg_we),
        .cfg_idx       (cfg_idx),
        .cfg_char      (cfg_char),
        .cfg_len_we    (cfg_len_we),
        .cfg_len       (cfg_len),
        .overlap_en    (overlap_en),
        .ack           (ack),
        .found_pattern (found_s),
        .match_pulse   (pulse_s),
        .overrun       (overrun_s),
        .match_count   (count_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_edge();
        bit hit;
        hit = 1'b0;
        if (!reset_sync_n) begin
            for (int i = 0; i < MAX_LEN; i++) m_pat[i] = '0;
            m_q.delete();
            m_len = 0; m_pos = 0; m_last_end = 0; m_cnt = 0;
            m_found = 1'b0; m_ovr = 1'b0; m_pulse = 1'b0;
            return;
        end
        if (cfg_we || cfg_len_we) begin
            if (cfg_we) m_pat[cfg_idx] = cfg_char;
            if (cfg_len_we) m_len = int'(cfg_len);
            m_q.delete();
            m_pos = 0;
            m_last_end = 0;
        end else if (data_valid) begin
            m_q.push_back(data);
            m_pos++;
            if (m_len >= 1 && m_len <= MAX_LEN && m_q.size() >= m_len) begin
                hit = 1'b1;
                for (int i = 0; i < m_len; i++) begin
                    if (m_q[m_q.size() - m_len + i] != m_pat[i]) hit = 1'b0;
                end
                if (!overlap_en && m_last_end != 0 && (m_pos - m_last_end) < m_len) hit = 1'b0;
            end
            if (hit && !overlap_en) m_last_end = m_pos;
            if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
        end
        m_pulse = hit;
        if (hit && m_found && !ack) m_ovr = 1'b1;
        else if (ack) m_ovr = 1'b0;
        m_found = hit | (m_found & ~ack);
        if (hit) m_cnt++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("match_pulse", match_pulse, m_pulse);
        chk("found_pattern", found_pattern, m_found);
        chk("overrun", overrun, m_ovr);
        chk("match_count", match_count, (m_cnt > 65535) ? 65535 : m_cnt);
        chk("sat_pulse", pulse_s, m_pulse);
        chk("sat_count", count_s, (m_cnt > 3) ? 3 : m_cnt);
    endtask

    task automatic do_reset();
        reset_sync_n = 1'b0;
        cycle();
        reset_sync_n = 1'b1;
    endtask

    task automatic set_pat(input string s, input int len);
        for (int i = 0; i < s.len(); i++) begin
            cfg_we = 1'b1; cfg_idx = 3'(i); cfg_char = s[i];
            cycle();
        end
        cfg_we = 1'b0;
        cfg_len_we = 1'b1; cfg_len = 4'(len);
        cycle();
        cfg_len_we = 1'b0;
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            data_valid = 1'b1; data = s[i];
            cycle();
        end
        data_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        string s;
        do_reset();
        chk("reset_found", found_pattern, 0);
        chk("reset_count", match_count, 0);

        overlap_en = 1'b1;
        set_pat("boab", 4);
        send("pbbboabzboabzboabz");
        idle(1);
        chk("boab_count", match_count, 3);
        chk("boab_overrun", overrun, 1);

        do_reset();
        overlap_en = 1'b1;
        set_pat("aa", 2);
        send("aaaa");
        idle(1);
        chk("aa_overlap_count", match_count, 3);
        do_reset();
        overlap_en = 1'b0;
        set_pat("aa", 2);
        send("aaaa");
        idle(1);
        chk("aa_nonoverlap_count", match_count, 2);

        do_reset();
        set_pat("ab", 2);
        send("ab");
        idle(3);
        ack = 1'b1; cycle(); ack = 1'b0;
        chk("ack_clears", found_pattern, 0);
        data_valid = 1'b1; data = "a"; cycle();
        data = "b"; ack = 1'b1; cycle();
        ack = 1'b0; data_valid = 1'b0;
        chk("ack_match_found", found_pattern, 1);
        chk("ack_match_overrun", overrun, 0);

        do_reset();
        overlap_en = 1'b1;
        set_pat("boab", 4);
        send("bo");
        cfg_we = 1'b1; cfg_idx = 3'd3; cfg_char = "b"; cycle(); cfg_we = 1'b0;
        send("ab");
        chk("flush_nomatch", match_count, 0);
        send("boab");
        idle(1);
        chk("flush_then_match", match_count, 1);

        do_reset();
        set_pat("ab", 0);
        send("ababab");
        set_pat("abcdefgh", 9);
        send("abcdefghabcdefgh");
        idle(1);
        chk("len_disabled", match_count, 0);
        set_pat("abcdefgh", 8);
        send("xabcdefgh");
        idle(1);
        chk("len_max", match_count, 1);

        do_reset();
        overlap_en = 1'b0;
        set_pat("z", 1);
        send("zzz");
        idle(1);
        chk("len1_nonoverlap", match_count, 3);
        send("zz");
        idle(1);
        chk("sat_at_3", count_s, 3);
        chk("nosat_5", match_count, 5);

        do_reset();
        set_pat("boab", 4);
        send("bo");
        do_reset();
        send("ab");
        idle(1);
        chk("reset_mid_count", match_count, 0);
        chk("reset_mid_found", found_pattern, 0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 4) begin
                s = "";
                for (int i = 0; i < $urandom_range(1, 3); i++) s = {s, ($urandom_range(0, 1) != 0) ? "a" : "b"};
                overlap_en = 1'($urandom_range(0, 1));
                set_pat(s, (s.len() == 3 && $urandom_range(0, 3) == 0) ? 0 : s.len());
            end
            data_valid = 1'($urandom_range(0, 3) != 0);
            data = "a" + 8'($urandom_range(0, 2));
            ack = 1'($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 49) == 0) begin
                cfg_we = 1'b1; cfg_idx = 3'($urandom_range(0, 2)); cfg_char = "a" + 8'($urandom_range(0, 1));
            end
            cycle();
            cfg_we = 1'b0;
        end
        data_valid = 1'b0; ack = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
